mc_mem_if: RTL and testbench

MC_MEM_IF -- requirements
Module: mc_mem_if

---
 rtl/mc_mem_if.sv | 168 ++++++++++++++++
 tb/tb_mc_mem_if.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_mem_if.sv
// Memory interface between the multicycle control FSM and a ready-strobed memory.
// Handles fetch/load/store handshakes, stalls the FSM via CE, and traps faults.
module mc_mem_if #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IRWrite,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic          AdrSrc,
    input  logic [AW-1:0] PC,
    input  logic [AW-1:0] ALUOut,
    input  logic [AW-1:0] WData,
    input  logic          mem_ready,
    input  logic [AW-1:0] mem_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    output logic          CE,
    output logic [AW-1:0] IR,
    output logic [AW-1:0] OldPC,
    output logic [AW-1:0] Data,
    output logic          fault
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE,
        HALT
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          rd_q, rd_d;
    logic          fe_q, fe_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          fault_q, fault_d;
    logic [AW-1:0] ir_q, ir_d;
    logic [AW-1:0] oldpc_q, oldpc_d;
    logic [AW-1:0] data_q, data_d;

    logic          acc;
    logic [AW-1:0] sel_addr;
    logic          aligned;

    assign acc      = IRWrite | MemRead | MemWrite;
    assign sel_addr = AdrSrc ? ALUOut : PC;
    assign aligned  = (sel_addr[1:0] == 2'b00);

    // Next-state, register loads and handshake outputs; reset forces idle outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rd_d      = rd_q;
        fe_d      = fe_q;
        cnt_d     = cnt_q;
        fault_d   = fault_q;
        ir_d      = ir_q;
        oldpc_d   = oldpc_q;
        data_d    = data_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        CE        = 1'b0;
        case (state_q)
            IDLE: begin
                mem_addr  = sel_addr;
                mem_wdata = WData;
                if (!acc) begin
                    CE = 1'b1;
                end else if (!aligned) begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = MemWrite;
                    addr_d  = sel_addr;
                    wdata_d = WData;
                    we_d    = MemWrite;
                    rd_d    = !MemWrite && MemRead;
                    fe_d    = !MemWrite && !MemRead;
                    cnt_d   = 8'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                mem_we  = we_q;
                if (mem_ready) begin
                    if (fe_q) begin
                        ir_d    = mem_rdata;
                        oldpc_d = addr_q;
                    end
                    if (rd_q) begin
                        data_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                CE      = 1'b1;
                state_d = IDLE;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (RST) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            CE      = 1'b1;
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            fe_q    <= 1'b0;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
            ir_q    <= '0;
            oldpc_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            fe_q    <= fe_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            ir_q    <= ir_d;
            oldpc_q <= oldpc_d;
            data_q  <= data_d;
        end
    end

    assign IR    = ir_q;
    assign OldPC = oldpc_q;
    assign Data  = data_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_mc_mem_if.sv
// Directed self-checking bench for mc_mem_if.
// Fetch, load, store, priority, misalign, timeout and reset scenarios.
module tb_mc_mem_if;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IRWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        AdrSrc = 1'b0;
    logic [31:0] PC = '0;
    logic [31:0] ALUOut = '0;
    logic [31:0] WData = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        CE;
    logic [31:0] IR;
    logic [31:0] OldPC;
    logic [31:0] Data;
    logic        fault;

    int n_chk = 0;
    int n_fail = 0;

    mc_mem_if #(
        .TIMEOUT(4),
        .AW(32)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .IRWrite(IRWrite),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .AdrSrc(AdrSrc),
        .PC(PC),
        .ALUOut(ALUOut),
        .WData(WData),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .CE(CE),
        .IR(IR),
        .OldPC(OldPC),
        .Data(Data),
        .fault(fault)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // reset held
        step();
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_ce", 32'(CE), 32'd1);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_ir", IR, 32'h0);
        check("rst_oldpc", OldPC, 32'h0);
        check("rst_data", Data, 32'h0);
        IRWrite = 1'b1;
        #1;
        check("rst_acc_req", 32'(mem_req), 32'd0);
        check("rst_acc_ce", 32'(CE), 32'd1);
        IRWrite = 1'b0;
        step();
        RST = 1'b0;
        #1;
        check("idle_ce", 32'(CE), 32'd1);
        check("idle_req", 32'(mem_req), 32'd0);

        // reset mid-WAIT with mem_ready on the same edge
        IRWrite = 1'b1;
        PC = 32'h20;
        #1;
        check("r_req0", 32'(mem_req), 32'd1);
        step();
        RST = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        #1;
        step();
        RST = 1'b0;
        IRWrite = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("r_ir", IR, 32'h0);
        check("r_oldpc", OldPC, 32'h0);
        check("r_req", 32'(mem_req), 32'd0);
        check("r_ce_idle", 32'(CE), 32'd1);

        // fetch, ready on 3rd WAIT cycle
        PC = 32'h10;
        AdrSrc = 1'b0;
        IRWrite = 1'b1;
        #1;
        check("f_req", 32'(mem_req), 32'd1);
        check("f_addr", mem_addr, 32'h10);
        check("f_we", 32'(mem_we), 32'd0);
        check("f_ce0", 32'(CE), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            PC = 32'h998;
            if (i == 3) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h00500093;
            end
            #1;
            check("f_w_req", 32'(mem_req), 32'd1);
            check("f_w_addr", mem_addr, 32'h10);
            check("f_w_ce", 32'(CE), 32'd0);
        end
        step();
        IRWrite = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("f_done_ce", 32'(CE), 32'd1);
        check("f_done_req", 32'(mem_req), 32'd0);
        check("f_ir", IR, 32'h00500093);
        check("f_oldpc", OldPC, 32'h10);

        // load immediately after; zero-wait memory
        step();
        AdrSrc = 1'b1;
        ALUOut = 32'h100;
        MemRead = 1'b1;
        #1;
        check("l_ce0", 32'(CE), 32'd0);
        check("l_req", 32'(mem_req), 32'd1);
        check("l_addr", mem_addr, 32'h100);
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE0001;
        #1;
        check("l_w_ce", 32'(CE), 32'd0);
        step();
        MemRead = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("l_done_ce", 32'(CE), 32'd1);
        check("l_data", Data, 32'hCAFE0001);
        check("l_ir", IR, 32'h00500093);
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'h11111111;
        #1;
        check("idle_rdy_req", 32'(mem_req), 32'd0);
        step();
        mem_ready = 1'b0;
        #1;
        check("idle_rdy_data", Data, 32'hCAFE0001);
        check("idle_rdy_ir", IR, 32'h00500093);

        // store, 2 WAIT cycles
        MemWrite = 1'b1;
        ALUOut = 32'h204;
        WData = 32'hDEADBEEF;
        #1;
        check("s_req", 32'(mem_req), 32'd1);
        check("s_we", 32'(mem_we), 32'd1);
        check("s_addr", mem_addr, 32'h204);
        check("s_wdata", mem_wdata, 32'hDEADBEEF);
        for (int i = 1; i <= 2; i++) begin
            step();
            ALUOut = 32'h300;
            WData = 32'h0;
            if (i == 2) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h22222222;
            end
            #1;
            check("s_w_req", 32'(mem_req), 32'd1);
            check("s_w_we", 32'(mem_we), 32'd1);
            check("s_w_addr", mem_addr, 32'h204);
            check("s_w_wdata", mem_wdata, 32'hDEADBEEF);
        end
        step();
        MemWrite = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("s_done_ce", 32'(CE), 32'd1);
        check("s_ir", IR, 32'h00500093);
        check("s_data", Data, 32'hCAFE0001);
        step();

        // read + fetch together: read wins
        IRWrite = 1'b1;
        MemRead = 1'b1;
        AdrSrc = 1'b1;
        ALUOut = 32'h40;
        PC = 32'h80;
        #1;
        check("p_addr", mem_addr, 32'h40);
        check("p_we", 32'(mem_we), 32'd0);
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'h33333333;
        #1;
        step();
        IRWrite = 1'b0;
        MemRead = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("p_data", Data, 32'h33333333);
        check("p_ir", IR, 32'h00500093);
        check("p_oldpc", OldPC, 32'h10);
        step();

        // misaligned load
        MemRead = 1'b1;
        AdrSrc = 1'b1;
        ALUOut = 32'h102;
        #1;
        check("m_req0", 32'(mem_req), 32'd0);
        check("m_ce0", 32'(CE), 32'd0);
        check("m_fault0", 32'(fault), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            mem_ready = 1'b1;
            mem_rdata = 32'h44444444;
            #1;
            check("m_fault", 32'(fault), 32'd1);
            check("m_req", 32'(mem_req), 32'd0);
            check("m_ce", 32'(CE), 32'd0);
        end
        step();
        check("m_data_held", Data, 32'h33333333);
        MemRead = 1'b0;
        mem_ready = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        check("m_rst_fault", 32'(fault), 32'd0);
        check("m_rst_ce", 32'(CE), 32'd1);

        // timeout with TIMEOUT=4
        IRWrite = 1'b1;
        AdrSrc = 1'b0;
        PC = 32'h44;
        #1;
        check("t_req0", 32'(mem_req), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("t_w_req", 32'(mem_req), 32'd1);
            check("t_w_fault", 32'(fault), 32'd0);
        end
        step();
        check("t_fault", 32'(fault), 32'd1);
        check("t_req", 32'(mem_req), 32'd0);
        check("t_ce", 32'(CE), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h55555555;
        step();
        check("t_halt_ir", IR, 32'h0);
        check("t_halt_fault", 32'(fault), 32'd1);
        check("t_halt_ce", 32'(CE), 32'd0);
        IRWrite = 1'b0;
        mem_ready = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        check("t_rst_fault", 32'(fault), 32'd0);
        check("t_rst_ce", 32'(CE), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
